// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and the serialiser state encoding.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head entry is readable
// combinationally so the consumer can latch it on the same edge it pops.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-attached 8N1 UART transmitter: register decode, TX FIFO, baud timing
// and the frame serialiser. Reads are combinational to match dmem timing.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] bus_A_i,
  input  logic [31:0] bus_WD_i,
  input  logic        bus_WE_i,
  input  logic [3:0]  bus_WMASK_i,
  output logic [31:0] bus_RD_o,
  output logic        bus_sel_o,
  output logic        tx_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic [1:0]    reg_idx;
  logic          wr_lane0;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          enable_reg;
  logic          overflow_reg;
  tx_state_e     state_reg;
  logic [BW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          baud_last;
  logic          unused_bits;

  assign unused_bits = ^{bus_WD_i[31:8], bus_WMASK_i[3:1], bus_A_i[1:0]};

  assign sel       = (bus_A_i[31:4] == BASE_ADDR[31:4]);
  assign reg_idx   = bus_A_i[3:2];
  assign wr_lane0  = sel & bus_WE_i & bus_WMASK_i[0];
  assign push      = wr_lane0 && (reg_idx == REG_TXDATA);
  assign baud_last = (baud_cnt_reg == BW'(CLKS_PER_BIT - 1));
  // The FIFO is only drained when a new frame can start right now.
  assign pop       = enable_reg && !fifo_empty &&
                     ((state_reg == IDLE) || ((state_reg == STOP) && baud_last));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .wdata  (bus_WD_i[7:0]),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      enable_reg   <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_lane0 && (reg_idx == REG_CTRL)) enable_reg <= bus_WD_i[0];
      if (push && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end else if (wr_lane0 && (reg_idx == REG_STATUS) && bus_WD_i[3]) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    bus_RD_o = '0;
    if (sel) begin
      case (reg_idx)
        REG_STATUS: begin
          bus_RD_o[ST_FULL]                 = fifo_full;
          bus_RD_o[ST_EMPTY]                = fifo_empty;
          bus_RD_o[ST_BUSY]                 = (state_reg != IDLE);
          bus_RD_o[ST_OVF]                  = overflow_reg;
          bus_RD_o[ST_CNT_LSB +: 8]         = 8'(fifo_count);
        end
        REG_CTRL: bus_RD_o[0] = enable_reg;
        default:  bus_RD_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          if (pop) begin
            state_reg <= START;
            shift_reg <= fifo_rdata;
            tx_reg    <= 1'b0;
          end
        end
        START: begin
          baud_cnt_reg <= baud_last ? '0 : baud_cnt_reg + 1'b1;
          if (baud_last) begin
            state_reg   <= DATA;
            bit_cnt_reg <= '0;
            tx_reg      <= shift_reg[0];
          end
        end
        DATA: begin
          baud_cnt_reg <= baud_last ? '0 : baud_cnt_reg + 1'b1;
          if (baud_last) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_reg    <= shift_reg[1];
            end
          end
        end
        STOP: begin
          baud_cnt_reg <= baud_last ? '0 : baud_cnt_reg + 1'b1;
          if (baud_last) begin
            if (pop) begin
              state_reg <= START;
              shift_reg <= fifo_rdata;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus_sel_o = sel;
  assign tx_o      = tx_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx against a frame-position reference model.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, wd;
  logic        we;
  logic [3:0]  m;
  logic [31:0] rd;
  logic        sel;
  logic        tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus_A_i     (a),
    .bus_WD_i    (wd),
    .bus_WE_i    (we),
    .bus_WMASK_i (m),
    .bus_RD_o    (rd),
    .bus_sel_o   (sel),
    .tx_o        (tx)
  );

  // Reference model: a byte queue plus "which cycle of which frame" on the wire.
  logic [7:0] q[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_en;
  bit         m_ovf;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  function automatic void model_reset();
    q.delete();
    m_active = 0;
    m_pos    = 0;
    m_cur    = 8'h00;
    m_en     = 1;
    m_ovf    = 0;
  endfunction

  function automatic logic model_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    logic [31:0] r;
    r = 32'h0;
    if (addr[31:4] == BASE[31:4]) begin
      case (addr[3:2])
        2'd1: begin
          r[0]    = (q.size() == DEPTH);
          r[1]    = (q.size() == 0);
          r[2]    = m_active;
          r[3]    = m_ovf;
          r[15:8] = 8'(q.size());
        end
        2'd2:    r[0] = m_en;
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] aa, input logic [31:0] dd,
                      input logic w, input logic [3:0] mm);
    logic    hit, wr;
    logic [1:0] idx;
    bit      fe, cs;
    rst_n = r; a = aa; wd = dd; we = w; m = mm;
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      hit = (aa[31:4] == BASE[31:4]);
      idx = aa[3:2];
      wr  = hit && w && mm[0];
      fe  = m_active && (m_pos == 10*CPB - 1);
      cs  = (!m_active || fe) && m_en && (q.size() > 0);
      if (m_active) begin
        m_pos++;
        if (fe) m_active = 0;
      end
      if (cs) begin
        m_cur    = q.pop_front();
        m_active = 1;
        m_pos    = 0;
      end
      if (wr && idx == 2'd0) begin
        if (q.size() < DEPTH) q.push_back(dd[7:0]);
        else m_ovf = 1;
      end
      if (wr && idx == 2'd1 && dd[3]) m_ovf = 0;
      if (wr && idx == 2'd2) m_en = dd[0];
    end
    if (w) $display("wr addr=0x%08h data=0x%08h mask=%b rst_n=%b qlen=%0d", aa, dd, mm, r, q.size());
    #1;
    chk("tx", {31'b0, tx}, {31'b0, model_tx()});
    chk("sel", {31'b0, sel}, {31'b0, (aa[31:4] == BASE[31:4])});
    chk("rd", rd, model_rd(aa));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, BASE + 32'h4, 32'h0, 1'b0, 4'b0000);
  endtask

  initial begin
    int         busy_cnt;
    int         low_cnt;
    logic [9:0] frame_bits;
    int         sel_r;

    model_reset();
    rst_n = 1'b0; a = BASE + 32'h4; wd = '0; we = 1'b0; m = 4'b0000;

    vecs[0] = '{"sel_0fc",    32'h0000_00FC, 1'b0, 32'h0};
    vecs[1] = '{"status_rst", 32'h0000_0104, 1'b1, 32'h0000_0002};
    vecs[2] = '{"ctrl_rst",   32'h0000_0108, 1'b1, 32'h0000_0001};
    vecs[3] = '{"txdata_rd",  32'h0000_0100, 1'b1, 32'h0};
    vecs[4] = '{"reserved",   32'h0000_010C, 1'b1, 32'h0};
    vecs[5] = '{"sel_110",    32'h0000_0110, 1'b0, 32'h0};
    vecs[6] = '{"sel_000",    32'h0000_0004, 1'b0, 32'h0};

    step(1'b0, BASE + 32'h4, 32'h0, 1'b0, 4'b0000);
    step(1'b0, BASE + 32'h4, 32'h0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    chk("tx_after_reset", {31'b0, tx}, 32'h1);
    for (int i = 0; i < 7; i++) begin
      a = vecs[i].addr;
      #1;
      $display("rd addr=0x%08h sel=%b data=0x%08h", a, sel, rd);
      chk({vecs[i].name, "_sel"}, {31'b0, sel}, {31'b0, vecs[i].exp_sel});
      chk({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
    end

    // Single 0x55 frame: sample the middle of each bit period.
    step(1'b1, BASE, 32'h0000_0055, 1'b1, 4'b0001);
    busy_cnt = 0;
    frame_bits = '0;
    for (int i = 0; i < 45; i++) begin
      idle(1);
      if (rd[2]) busy_cnt++;
      if (i < 10*CPB && (i % CPB) == CPB/2) frame_bits[i/CPB] = tx;
    end
    chk("frame_55_bits", {22'b0, frame_bits}, 32'h0000_02AA);
    chk("frame_55_busy", busy_cnt, 10*CPB);
    chk("status_after_frame", rd, 32'h0000_0002);

    // Store without lane 0 must not push.
    step(1'b1, BASE, 32'h0000_00AB, 1'b1, 4'b0010);
    idle(10);
    chk("lane1_only_status", rd, 32'h0000_0002);

    // Fill with TX disabled, overflow on the ninth byte, then W1C.
    step(1'b1, BASE + 32'h8, 32'h0, 1'b1, 4'b0001);
    for (int i = 0; i < 9; i++) step(1'b1, BASE, 32'h10 + i, 1'b1, 4'b0001);
    idle(3);
    chk("status_full_ovf", rd, 32'h0000_0809);
    step(1'b1, BASE + 32'h4, 32'h0000_0008, 1'b1, 4'b0001);
    chk("status_ovf_clr", rd, 32'h0000_0801);

    // Re-enable: eight back-to-back frames with no idle gap.
    step(1'b1, BASE + 32'h8, 32'h1, 1'b1, 4'b0001);
    busy_cnt = 0;
    for (int i = 0; i < 80*CPB + 10; i++) begin
      idle(1);
      if (rd[2]) busy_cnt++;
    end
    chk("b2b_busy", busy_cnt, 80*CPB);
    chk("status_after_b2b", rd, 32'h0000_0002);

    // Reset in the middle of a frame with more bytes queued.
    step(1'b1, BASE, 32'h0000_00A5, 1'b1, 4'b0001);
    step(1'b1, BASE, 32'h0000_003C, 1'b1, 4'b0001);
    step(1'b1, BASE, 32'h0000_00F0, 1'b1, 4'b0001);
    for (int i = 0; i < 100 && !(m_active && m_pos == 14); i++) idle(1);
    step(1'b0, BASE + 32'h4, 32'h0, 1'b0, 4'b0000);
    chk("tx_mid_reset", {31'b0, tx}, 32'h1);
    idle(1);
    chk("status_post_reset", rd, 32'h0000_0002);
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      if (!tx) low_cnt++;
    end
    chk("no_frames_post_reset", low_cnt, 0);

    // Randomised bus traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      sel_r = $urandom_range(0, 19);
      case (sel_r)
        0, 1:  step(1'b1, BASE, $urandom, 1'b1, 4'($urandom_range(0, 15)) | 4'b0001);
        2:     step(1'b1, BASE, $urandom, 1'b1, 4'($urandom_range(0, 15)));
        3:     step(1'b1, BASE + 32'h4, $urandom, 1'b1, 4'($urandom_range(0, 15)));
        4:     step(1'b1, BASE + 32'h8, {31'b0, ($urandom_range(0, 3) != 0)}, 1'b1,
                    4'($urandom_range(0, 15)));
        5:     step(1'b1, BASE + 32'hC, $urandom, 1'b1, 4'b1111);
        6:     step(1'b1, BASE + 32'h10, $urandom, 1'b1, 4'b1111);
        7:     step(1'b1, BASE + 32'h8, $urandom, 1'b0, 4'b0000);
        default: idle(1);
      endcase
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the core's data-memory bus, alongside `dmem`. It decodes a small register window and buffers store bytes in a FIFO. It serialises each byte as an 8N1 frame on `tx_o`, giving core programs a character output channel. Reads are combinational, matching `dmem` timing, so the single-cycle core needs no stall.

## Interface
- `BASE_ADDR`, default 32'h0000_0100: 16-byte-aligned base of the register window, outside the 256-byte `dmem`.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, ≥ 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries, a power of two in 2..128.
- `clk_i  in  1`: clock, all state updates on rising edge.
- `rst_ni  in  1`: synchronous active-low reset.
- `bus_A_i  in  32`: byte address from the core (`dmem_A_o`).
- `bus_WD_i  in  32`: write data (`dmem_WD_o`).
- `bus_WE_i  in  1`: write enable (`dmem_WE_o`).
- `bus_WMASK_i  in  4`: byte-lane write mask (`dmem_WMASK_o`).
- `bus_RD_o  out  32`: combinational read data, 0 when not selected.
- `bus_sel_o  out  1`: combinational address hit; top level uses it to mux `bus_RD_o` over `dmem` read data.
- `tx_o  out  1`: serial output, idle high, registered.

## Operation
- Hit: `bus_A_i[31:4] == BASE_ADDR[31:4]`. Register select is `bus_A_i[3:2]`.
- 0 TXDATA: write with `bus_WMASK_i[0]=1` pushes `bus_WD_i[7:0]`. Lanes 1-3 are ignored, and a write without lane 0 pushes nothing. Reads return 0.
- 1 STATUS, read:
  - [0] full.
  - [1] empty.
  - [2] busy (FSM not IDLE).
  - [3] overflow, sticky.
  - [15:8] FIFO count.
  - Other bits 0.
- 1 STATUS, write: write with lane 0 and `bus_WD_i[3]=1` clears overflow (W1C). Other bits are ignored.
- 2 CTRL: bit0 enable, R/W via lane 0, reset value 1. Other bits read 0.
- 3: reserved. Reads return 0; writes are ignored.
- Push when full and no pop that cycle: byte dropped, overflow set.
- Push and pop in the same cycle:
  - If full, the push is accepted and the count is unchanged.
  - If empty, the pop cannot occur and the count becomes 1.
- FSM states IDLE, START, DATA, STOP:
  - IDLE → START when enable=1 and FIFO not empty. The pop happens on this edge and the byte is latched into the shift register.
  - START: `tx_o=0` for CLKS_PER_BIT cycles, then → DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles, tracked by a 3-bit bit counter. After bit 7 → STOP.
  - STOP: `tx_o=1` for CLKS_PER_BIT cycles. At the last cycle, if enable=1 and FIFO not empty, pop and → START (back-to-back frames); otherwise → IDLE.
- Clearing enable mid-frame: current frame completes and no further pops occur. Setting enable resumes from IDLE.
- Reset values: `tx_o=1`, FSM IDLE, FIFO empty, overflow 0, enable 1, counters 0. Reset mid-frame aborts the frame and drops FIFO contents.

## Timing
- Write to TXDATA at edge k, with FIFO empty, FSM IDLE and enable=1:
  - Count is 1 after edge k.
  - Pop and `tx_o` falls at edge k+1.
  - Frame occupies exactly 10·CLKS_PER_BIT cycles.
- Busy asserts from edge k+1 and deasserts at the edge ending STOP, unless a back-to-back pop occurs.
- STATUS and CTRL reads reflect state after the most recent edge (combinational read).
- CTRL write at edge k takes effect for the IDLE decision at edge k+1.
- Baud counter wraps from CLKS_PER_BIT-1 to 0.
- Bit counter wraps from 7 only on the DATA → STOP transition.

## Structure
- Package `uart_pkg`:
  - Register offsets, TXDATA=0, STATUS=1, CTRL=2.
  - STATUS bit indices.
  - FSM state enum `tx_state_e`.
- Sub-module `sync_fifo`:
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Pointers one bit wider than the address.
  - Reset also synchronous active-low.
- `mmio_uart_tx` holds the decode, CTRL/overflow registers, baud counter, shift register and FSM.

## Test plan
- Reset: `rst_ni` low 2 cycles → `tx_o=1`; STATUS read = 32'h0000_0002; CTRL read = 32'h1; `bus_sel_o=0` for address 0x0FC, 1 for 0x104.
- CLKS_PER_BIT=4, write 0x55 mask 4'b0001 to BASE+0 → `tx_o` low from next edge for 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), stop high 4 cycles; busy for 40 cycles, then STATUS = 0x2.
- Write 0xAB to BASE+0 with mask 4'b0010 → STATUS stays 0x2, `tx_o` stays 1.
- CTRL=0, write 9 bytes → STATUS = 32'h0000_0809 (count 8, overflow, full); write 0x8 to STATUS → 32'h0000_0801.
- Then CTRL=1 → 8 contiguous frames (80·CLKS_PER_BIT cycles) in write order, no idle gap; final STATUS = 0x2.
- Assert reset at cycle 15 of a frame with 3 bytes queued → `tx_o=1` after that edge; STATUS = 0x2 after release; no further frames.
